// File: rtl/fft16_pkg.sv
// Shared constants and packed complex-sample type for the 16-point FFT output path.
package fft16_pkg;

    localparam int N     = 16;
    localparam int DW    = 16;
    localparam int LOG2N = 4;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft16_frame_bank.sv
// One 16-entry complex frame buffer: parallel write of a whole frame, single indexed read.
module fft16_frame_bank
    import fft16_pkg::*;
(
    input  logic               clk,
    input  logic               i_we,
    input  logic [N*DW-1:0]    i_re,
    input  logic [N*DW-1:0]    i_im,
    input  logic [LOG2N-1:0]   i_idx,
    output cplx_t              o_data
);

    cplx_t r_mem [N];

    // Contents are intentionally not reset; validity is tracked by the owner's full flags.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned k = 0; k < N; k++) begin
                r_mem[k].re <= i_re[DW*k +: DW];
                r_mem[k].im <= i_im[DW*k +: DW];
            end
        end
    end

    assign o_data = r_mem[i_idx];

endmodule

// File: rtl/fft16_output_serializer.sv
// Ping-pong serializer: captures a parallel 16-bin FFT frame and streams it in natural order.
// Optional 1/N output normalisation is enabled by defining FFT16_OUT_SCALE_EN.
module fft16_output_serializer #(
    parameter int DW = fft16_pkg::DW,
    parameter int N  = fft16_pkg::N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_re,
    input  logic [N*DW-1:0] in_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_re,
    output logic [DW-1:0]   out_im,
    output logic [3:0]      out_idx,
    output logic            out_sof,
    output logic            out_eof,
    output logic [7:0]      drop_cnt
);
    import fft16_pkg::*;

    logic [1:0]       r_full;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [LOG2N-1:0] r_idx;
    logic [7:0]       r_drop;

    cplx_t w_rd [2];
    cplx_t w_cur;
    logic  w_cap;
    logic  w_beat;
    logic  w_wrap;

    assign in_ready  = !r_full[r_wr_ptr];
    assign out_valid = r_full[r_rd_ptr];
    assign w_cap     = in_valid && in_ready;
    assign w_beat    = out_valid && out_ready;
    assign w_wrap    = w_beat && (r_idx == LOG2N'(N - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft16_frame_bank u_bank (
            .clk    (clk),
            .i_we   (w_cap && (r_wr_ptr == 1'(b))),
            .i_re   (in_re),
            .i_im   (in_im),
            .i_idx  (r_idx),
            .o_data (w_rd[b])
        );
    end

    // Capture and release always target different banks, so both may act on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_idx    <= '0;
            r_drop   <= '0;
        end else begin
            if (w_cap) begin
                r_full[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_beat) begin
                r_idx <= r_idx + 1'b1;
                if (w_wrap) begin
                    r_full[r_rd_ptr] <= 1'b0;
                    r_rd_ptr         <= ~r_rd_ptr;
                end
            end
            if (in_valid && !in_ready && (r_drop != '1))
                r_drop <= r_drop + 1'b1;
        end
    end

    assign w_cur = r_rd_ptr ? w_rd[1] : w_rd[0];

`ifdef FFT16_OUT_SCALE_EN
    logic signed [DW:0] w_re_sum;
    logic signed [DW:0] w_im_sum;

    // Sign-extend by one bit so the +8 rounding term cannot overflow before the shift.
    assign w_re_sum = {w_cur.re[DW-1], w_cur.re} + (DW+1)'(1 << (LOG2N - 1));
    assign w_im_sum = {w_cur.im[DW-1], w_cur.im} + (DW+1)'(1 << (LOG2N - 1));
    assign out_re   = DW'(w_re_sum >>> LOG2N);
    assign out_im   = DW'(w_im_sum >>> LOG2N);
`else
    assign out_re   = w_cur.re;
    assign out_im   = w_cur.im;
`endif

    assign out_idx  = r_idx;
    assign out_sof  = (r_idx == '0);
    assign out_eof  = (r_idx == LOG2N'(N - 1));
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_fft16_output_serializer.sv
// Directed self-checking bench for fft16_output_serializer (pass-through or FFT16_OUT_SCALE_EN build).
module tb_fft16_output_serializer;

    localparam int DW = 16;
    localparam int N  = 16;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_re;
    logic [N*DW-1:0] in_im;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_re;
    logic [DW-1:0]   out_im;
    logic [3:0]      out_idx;
    logic            out_sof;
    logic            out_eof;
    logic [7:0]      drop_cnt;

    int n_check = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    fft16_output_serializer #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output component for a stored input component.
    function automatic logic [15:0] model(input logic [15:0] x);
`ifdef FFT16_OUT_SCALE_EN
        logic signed [16:0] s;
        s = $signed({x[15], x}) + 17'sd8;
        return 16'(s >>> 4);
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane k gets re = rb + k, im = ib - k.
    task automatic set_frame(input int rb, input int ib);
        for (int k = 0; k < N; k++) begin
            in_re[DW*k +: DW] = 16'(rb + k);
            in_im[DW*k +: DW] = 16'(ib - k);
        end
    endtask

    task automatic chk_beat(input string tag, input int k, input int re, input int im);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"},   32'(out_idx),   32'(k));
        chk({tag, "_re"},    32'(out_re),    32'(model(16'(re))));
        chk({tag, "_im"},    32'(out_im),    32'(model(16'(im))));
        chk({tag, "_sof"},   32'(out_sof),   32'(k == 0));
        chk({tag, "_eof"},   32'(out_eof),   32'(k == 15));
    endtask

    initial begin
        int e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re     = '0;
        in_im     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_sof",       32'(out_sof),   32'd1);
        chk("rst_eof",       32'(out_eof),   32'd0);
        chk("rst_drop",      32'(drop_cnt),  32'd0);
        rst_n = 1'b1;

        // Single frame re=k, im=-k, first sample one cycle after capture
        @(negedge clk);
        set_frame(0, 0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("f1_pre_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_beat("f1", k, k, -k);
            @(negedge clk);
        end
        chk("f1_post_valid", 32'(out_valid), 32'd0);

        // Back-to-back frames, 32 contiguous beats, third frame dropped
        set_frame(100, 200);
        in_valid = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 32; j++) begin
            if (j == 0) begin
                chk("f2_ready_b", 32'(in_ready), 32'd1);
                set_frame(300, 400);
            end
            if (j == 1) begin
                chk("f2_ready_full", 32'(in_ready), 32'd0);
                set_frame(500, 600);
            end
            if (j == 2) begin
                in_valid = 1'b0;
                chk("f2_drop1", 32'(drop_cnt), 32'd1);
            end
            if (j == 15) chk("f2_ready_busy", 32'(in_ready), 32'd0);
            if (j == 16) chk("f2_ready_freed", 32'(in_ready), 32'd1);
            if (j < 16) chk_beat("f2a", j, 100 + j, 200 - j);
            else        chk_beat("f2b", j - 16, 300 + j - 16, 400 - (j - 16));
            @(negedge clk);
        end
        chk("f2_post_valid", 32'(out_valid), 32'd0);

        // Stalls: out_ready 1,0,1,0...
        set_frame(1000, 0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        e = 0;
        for (int c = 0; c < 31; c++) begin
            chk_beat("f3", e, 1000 + e, -e);
            out_ready = (c % 2 == 0);
            @(negedge clk);
            if (out_ready) e++;
        end
        chk("f3_post_valid", 32'(out_valid), 32'd0);

        // Boundary values through the (optional) scaler
        in_re = '0;
        in_im = '0;
        in_re[15:0]  = 16'h7FFF;
        in_re[31:16] = 16'h8000;
        in_re[47:32] = 16'hFFF7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef FFT16_OUT_SCALE_EN
        chk("sc_pos", 32'(out_re), 32'h0800);
        @(negedge clk);
        chk("sc_neg", 32'(out_re), 32'hF800);
        @(negedge clk);
        chk("sc_m9",  32'(out_re), 32'hFFFF);
`else
        chk("sc_pos", 32'(out_re), 32'h7FFF);
        @(negedge clk);
        chk("sc_neg", 32'(out_re), 32'h8000);
        @(negedge clk);
        chk("sc_m9",  32'(out_re), 32'hFFF7);
`endif
        chk("sc_idx", 32'(out_idx), 32'd2);
        chk("sc_im",  32'(out_im),  32'd0);
        repeat (14) @(negedge clk);
        chk("sc_post_valid", 32'(out_valid), 32'd0);

        // Reset mid-frame after beat 7
        set_frame(2000, 50);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_beat("f4", k, 2000 + k, 50 - k);
            @(negedge clk);
        end
        chk("f4_pre_rst_idx", 32'(out_idx), 32'd8);
        rst_n = 1'b0;
        #1;
        chk("f4_rst_valid", 32'(out_valid), 32'd0);
        chk("f4_rst_drop",  32'(drop_cnt),  32'd0);
        chk("f4_rst_idx",   32'(out_idx),   32'd0);
        chk("f4_rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        set_frame(3000, 70);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_beat("f5", k, 3000 + k, 70 - k);
            @(negedge clk);
        end
        chk("f5_post_valid", 32'(out_valid), 32'd0);

        // 300 refused frames with both banks held full
        out_ready = 1'b0;
        set_frame(4000, 0);
        in_valid = 1'b1;
        @(negedge clk);
        set_frame(5000, 0);
        @(negedge clk);
        chk("sat_ready", 32'(in_ready), 32'd0);
        repeat (10) @(negedge clk);
        chk("sat_drop10", 32'(drop_cnt), 32'd10);
        repeat (290) @(negedge clk);
        in_valid = 1'b0;
        chk("sat_drop255", 32'(drop_cnt), 32'd255);
        chk_beat("sat_hold", 0, 4000, 0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
